div4_seq: RTL and testbench
===========================

DIV4_SEQ -- requirements
Module: div4_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on this edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend; captured on an accepted start.
REQ-006 divisor  input  4  unsigned divisor; captured on an accepted start.
REQ-007 busy  output  1  high in CALC and DONE.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  4  unsigned quotient; holds until the next accepted start.
REQ-010 remainder  output  4  unsigned remainder; holds until the next accepted start.
REQ-011 div_by_zero  output  1  set when the captured divisor was 0; holds with the results.

Function
REQ-012 Algorithm SHALL be restoring division, one quotient bit per cycle, MSB first.
- 5-bit partial remainder P.
- Per step: P = {P[3:0], next dividend bit}.
- If P >= divisor: P = P - divisor and the quotient bit = 1; otherwise the quotient bit = 0.
REQ-013 States SHALL be IDLE, CALC and DONE.
- IDLE->CALC on start=1.
- CALC->DONE after exactly 4 CALC cycles, counted by a 2-bit step counter.
- DONE->IDLE unconditionally after 1 cycle.
REQ-014 An accepted start SHALL capture dividend and divisor, clear P, quotient, remainder and the step counter, and set div_by_zero = (divisor==0).
REQ-015 Latency: with start sampled at edge N, done SHALL be high for exactly the cycle following edge N+5, and quotient/remainder SHALL be valid in that cycle.
REQ-016 quotient and remainder SHALL NOT change during CALC; they load only on the CALC->DONE transition.
REQ-017 start while busy=1 SHALL be ignored, with no effect on the in-flight operation or the captured operands.
REQ-018 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only, so back-to-back operations run every 6 cycles.
REQ-019 Divisor 0 SHALL take no special path: the same 4-cycle flow yields quotient=4'hF, remainder=dividend and div_by_zero=1.
REQ-020 All arithmetic SHALL be unsigned with no overflow for any 4-bit operands; the result SHALL always satisfy remainder < divisor when divisor != 0.
REQ-021 Operand inputs SHALL be ignored outside the start-accept edge.

Reset
REQ-022 rst=1 SHALL force IDLE with busy, done, quotient, remainder, div_by_zero, P and the step counter all 0 on the next edge.
REQ-023 rst SHALL take priority over start and over any in-flight state.
REQ-024 rst asserted mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-025 The block SHALL accept start on the first edge where rst=0.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE), the operand width constant (4) and the step count constant (4).
REQ-027 The compare-and-subtract SHALL be built as a ripple chain of a sub-module full_sub.
- Ports: a, b, bin, d, bout.
- d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
- 5 instances; the final borrow-out = 0 means P >= divisor.
REQ-028 RTL SHALL contain no latches, no multi-cycle paths and no division operator.

Verification
REQ-029 13/3: start with dividend=13, divisor=3 -> done exactly 5 cycles later, quotient=4, remainder=1, div_by_zero=0.
REQ-030 15/1 and 2/5 -> quotient=15, remainder=0, then quotient=0, remainder=2, each run with a single done pulse.
REQ-031 7/0 -> quotient=4'hF, remainder=7, div_by_zero=1, same 5-cycle latency.
REQ-032 Busy start: 9/2 started, then start with 14/7 two cycles later -> 14/7 ignored, result quotient=4, remainder=1, and the outputs hold after done.
REQ-033 Reset mid-op: start 12/5, assert rst in the 2nd CALC cycle -> no done pulse, all outputs 0, IDLE; then 12/5 -> quotient=2, remainder=2.
REQ-034 Exhaustive: all 256 operand pairs -> every non-zero-divisor result matches the reference model, and every divisor=0 result matches REQ-019.

Source files
------------

// File: rtl/div4_seq_pkg.sv
// Shared types and constants for the 4-bit sequential restoring divider.
package div4_seq_pkg;

  localparam int unsigned OpWidth  = 4;
  localparam int unsigned NumSteps = 4;
  localparam int unsigned StepCntW = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } divStateE;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor; chained LSB-first to form the divider's compare-and-subtract.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/div4_seq.sv
// 4-bit unsigned restoring divider: one quotient bit per cycle, MSB first, four CALC cycles.
// done is registered off the DONE state, so it pulses in the cycle after DONE.
module div4_seq
  import div4_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OpWidth-1:0] dividend,
  input  logic [OpWidth-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [OpWidth-1:0] quotient,
  output logic [OpWidth-1:0] remainder,
  output logic               div_by_zero
);

  divStateE              stateQ, stateD;
  logic [StepCntW-1:0]   stepCntQ, stepCntD;
  logic [OpWidth-1:0]    dividendQ, dividendD;
  logic [OpWidth-1:0]    divisorQ, divisorD;
  logic [OpWidth-1:0]    qWorkQ, qWorkD;
  logic [OpWidth-1:0]    quotientQ, quotientD;
  logic [OpWidth-1:0]    remainderQ, remainderD;
  logic [OpWidth:0]      partRemQ, partRemD;
  logic                  divZeroQ, divZeroD;
  logic                  doneQ, doneD;

  // Bit position handled this step: step 0 works on the MSB.
  logic [StepCntW-1:0]   bitIdx;
  logic [OpWidth:0]      shifted;
  logic [OpWidth:0]      subtrahend;
  logic [OpWidth:0]      diff;
  logic [OpWidth+1:0]    borrow;
  logic                  geq;
  logic [OpWidth:0]      stepRem;
  logic                  lastStep;

  assign bitIdx     = StepCntW'(OpWidth - 1) - stepCntQ;
  assign shifted    = {partRemQ[OpWidth-1:0], dividendQ[bitIdx]};
  assign subtrahend = {1'b0, divisorQ};
  assign borrow[0]  = 1'b0;

  for (genvar i = 0; i <= OpWidth; i++) begin : gen_sub
    full_sub u_fullSub (
      .a    (shifted[i]),
      .b    (subtrahend[i]),
      .bin  (borrow[i]),
      .d    (diff[i]),
      .bout (borrow[i+1])
    );
  end

  // No borrow out of the top bit means the shifted remainder covers the divisor.
  assign geq      = ~borrow[OpWidth+1];
  assign stepRem  = geq ? diff : shifted;
  assign lastStep = (stepCntQ == StepCntW'(NumSteps - 1));

  always_comb begin
    stateD      = stateQ;
    stepCntD    = stepCntQ;
    dividendD   = dividendQ;
    divisorD    = divisorQ;
    qWorkD      = qWorkQ;
    quotientD   = quotientQ;
    remainderD  = remainderQ;
    partRemD    = partRemQ;
    divZeroD    = divZeroQ;
    doneD       = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          stateD     = StCalc;
          dividendD  = dividend;
          divisorD   = divisor;
          divZeroD   = (divisor == '0);
          stepCntD   = '0;
          partRemD   = '0;
          qWorkD     = '0;
          quotientD  = '0;
          remainderD = '0;
        end
      end
      StCalc: begin
        partRemD         = stepRem;
        qWorkD[bitIdx]   = geq;
        stepCntD         = stepCntQ + StepCntW'(1);
        if (lastStep) begin
          stateD     = StDone;
          quotientD  = qWorkD;
          remainderD = stepRem[OpWidth-1:0];
        end
      end
      StDone: begin
        stateD = StIdle;
        doneD  = 1'b1;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      stepCntQ   <= '0;
      dividendQ  <= '0;
      divisorQ   <= '0;
      qWorkQ     <= '0;
      quotientQ  <= '0;
      remainderQ <= '0;
      partRemQ   <= '0;
      divZeroQ   <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      stepCntQ   <= stepCntD;
      dividendQ  <= dividendD;
      divisorQ   <= divisorD;
      qWorkQ     <= qWorkD;
      quotientQ  <= quotientD;
      remainderQ <= remainderD;
      partRemQ   <= partRemD;
      divZeroQ   <= divZeroD;
      doneQ      <= doneD;
    end
  end

  assign busy        = (stateQ != StIdle);
  assign done        = doneQ;
  assign quotient    = quotientQ;
  assign remainder   = remainderQ;
  assign div_by_zero = divZeroQ;

  // A restored remainder is always below the divisor, so the top bit of P stays clear.
  always @(posedge clk) begin
    if (!rst && stateQ == StCalc) begin
      assert (!partRemQ[OpWidth])
        else $error("div4_seq: partial remainder overflowed");
    end
    if (!rst && doneQ && !divZeroQ) begin
      assert (remainderQ < divisorQ)
        else $error("div4_seq: remainder not below divisor");
    end
  end

endmodule

// File: tb/tb_div4_seq.sv
// Scoreboard bench for div4_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_div4_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
    string      name;
  } expT;

  expT sb[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;

  div4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        expT e;
        e = sb.pop_front();
        check({e.name, "_quotient"},  int'(quotient),    int'(e.q));
        check({e.name, "_remainder"}, int'(remainder),   int'(e.r));
        check({e.name, "_divzero"},   int'(div_by_zero), int'(e.dz));
        check({e.name, "_latency"},   cyc,               e.cyc);
      end
    end
  end

  // Waits for idle, issues one start, and registers the expected result.
  task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                       input logic [3:0] er, input logic edz, input string name);
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("idle_timeout", int'(busy), 0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{q: eq, r: er, dz: edz, cyc: cyc + 6, name: name});
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_divzero", int'(div_by_zero), 0);

    // Start held through the last reset edge: reset wins, then accepted on the first free edge.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    check("rst_over_start_busy", int'(busy), 0);
    rst = 1'b0;
    sb.push_back('{q: 4'd4, r: 4'd1, dz: 1'b0, cyc: cyc + 6, name: "div13_3"});
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    waitDrain();

    runOp(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "div15_1");
    runOp(4'd2,  4'd5, 4'd0,  4'd2, 1'b0, "div2_5");
    runOp(4'd7,  4'd0, 4'hF,  4'd7, 1'b1, "div7_0");
    waitDrain();

    // Start while busy must not disturb the running 9/2.
    runOp(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, "div9_2");
    @(posedge clk); #1;
    dividend = 4'd14;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_quotient", int'(quotient), 4);
    check("hold_remainder", int'(remainder), 1);
    check("hold_done", int'(done), 0);

    // Reset in the second CALC cycle aborts with no done pulse.
    @(posedge clk); #1;
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midop_busy", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_divzero", int'(div_by_zero), 0);
    repeat (8) @(posedge clk);
    #1;
    runOp(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, "div12_5");
    waitDrain();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] eq, er;
        logic       edz;
        if (b == 0) begin
          eq  = 4'hF;
          er  = 4'(a);
          edz = 1'b1;
        end else begin
          eq  = 4'(a / b);
          er  = 4'(a % b);
          edz = 1'b0;
        end
        runOp(4'(a), 4'(b), eq, er, edz, $sformatf("ex%0d_%0d", a, b));
      end
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
